// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter: log2(N) registered stages, valid/ready on both sides.
// Define SHIFT_UNIT_ROTATE_EN to build the rotate-left datapath for mode 11.
module pipelined_shift_unit #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [W-1:0] in_amt,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    // Registered state of each stage
    logic [N-1:0] stg_data [W];
    logic [W-1:0] stg_amt  [W];
    mode_e        stg_mode [W];
    logic         stg_sign [W];
    logic         stg_vld  [W];

    // Inputs seen by each stage and the values it will register
    logic [N-1:0] cur_data [W];
    logic [W-1:0] cur_amt  [W];
    mode_e        cur_mode [W];
    logic         cur_sign [W];
    logic         cur_vld  [W];
    logic [N-1:0] nxt_data [W];

    logic advance;

    // Shift by a fixed distance s; ASR fills from the carried sign, not the current MSB.
    function automatic logic [N-1:0] shift_by(input logic [N-1:0] d, input int unsigned s,
                                              input mode_e mode, input logic sign);
        logic [N-1:0] r;
        logic [N-1:0] fill;
        fill = sign ? ~({N{1'b1}} >> s) : '0;
        case (mode)
            MODE_LSR: r = d >> s;
            MODE_ASR: r = (d >> s) | fill;
`ifdef SHIFT_UNIT_ROTATE_EN
            MODE_ROL: r = (d << s) | (d >> (N - s));
`endif
            default:  r = d << s;
        endcase
        return r;
    endfunction

    assign advance   = !stg_vld[W-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = stg_vld[W-1];
    assign out_data  = stg_data[W-1];

    always_comb begin
        cur_data[0] = in_data;
        cur_amt[0]  = in_amt;
        cur_mode[0] = mode_e'(in_mode);
        cur_sign[0] = in_data[N-1];
        cur_vld[0]  = in_valid;
        for (int k = 1; k < W; k++) begin
            cur_data[k] = stg_data[k-1];
            cur_amt[k]  = stg_amt[k-1];
            cur_mode[k] = stg_mode[k-1];
            cur_sign[k] = stg_sign[k-1];
            cur_vld[k]  = stg_vld[k-1];
        end
        for (int k = 0; k < W; k++) begin
            nxt_data[k] = cur_amt[k][k] ? shift_by(cur_data[k], 1 << k, cur_mode[k], cur_sign[k])
                                        : cur_data[k];
        end
    end

    // NOTE: every stage register, data included, is reset so out_data reads 0 straight out of reset;
    // all state uses non-blocking assignments so each stage samples its predecessor's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < W; k++) begin
                stg_data[k] <= '0;
                stg_amt[k]  <= '0;
                stg_mode[k] <= MODE_LSL;
                stg_sign[k] <= 1'b0;
                stg_vld[k]  <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < W; k++) begin
                stg_data[k] <= nxt_data[k];
                stg_amt[k]  <= cur_amt[k];
                stg_mode[k] <= cur_mode[k];
                stg_sign[k] <= cur_sign[k];
                stg_vld[k]  <= cur_vld[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Scoreboard bench for pipelined_shift_unit (N = 8); honours SHIFT_UNIT_ROTATE_EN if defined.
module tb_pipelined_shift_unit;

    localparam int N = 8;
    localparam int W = $clog2(N);
    localparam int L = W;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [W-1:0] in_amt;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;

    pipelined_shift_unit #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int in_cnt = 0;
    int out_cnt = 0;
    logic [N-1:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-amount shift in one step, rotate as repeated single-bit rotation.
    function automatic logic [N-1:0] model(input logic [N-1:0] d, input int a, input logic [1:0] m);
        logic [N-1:0] r;
        case (m)
            2'd0: r = d << a;
            2'd1: r = d >> a;
            2'd2: r = $signed(d) >>> a;
            default: begin
`ifdef SHIFT_UNIT_ROTATE_EN
                r = d;
                for (int i = 0; i < a; i++) r = {r[N-2:0], r[N-1]};
`else
                r = d << a;
`endif
            end
        endcase
        return r;
    endfunction

    // Monitor: samples mid-cycle; the handshake completes on the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                sb.push_back(model(in_data, int'(in_amt), in_mode));
                in_cnt++;
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb.size() == 0) check("unexpected_output", 32'(out_valid), 32'd0);
                else check("result", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic send(input logic [N-1:0] d, input logic [W-1:0] a, input logic [1:0] m);
        logic rdy;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        do begin
            #1 rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) check("send_timeout", 32'(rdy), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] held;
    logic [N-1:0] rol_exp;
    logic         pend;
    logic         acc;
    int           sent;
    int           cyc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back LSL, LSR, ASR of 10110011 by 3
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'b1011_0011; in_amt = 3'd3; in_mode = 2'b00;
        @(posedge clk); #1 in_mode = 2'b01;
        @(posedge clk); #1 in_mode = 2'b10;
        check("latency_not_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        check("latency_valid", 32'(out_valid), 32'd1);
        check("lsl_3", 32'(out_data), 32'h98);
        @(posedge clk); #1;
        check("lsr_3_valid", 32'(out_valid), 32'd1);
        check("lsr_3", 32'(out_data), 32'h16);
        @(posedge clk); #1;
        check("asr_3_valid", 32'(out_valid), 32'd1);
        check("asr_3", 32'(out_data), 32'hF6);
        drain();

        // Mode 11, amount 3
`ifdef SHIFT_UNIT_ROTATE_EN
        rol_exp = 8'b1001_1101;
`else
        rol_exp = 8'b1001_1000;
`endif
        send(8'b1011_0011, 3'd3, 2'b11);
        in_valid = 1'b0;
        repeat (L - 1) @(posedge clk);
        #1 check("mode11_3", 32'(out_data), 32'(rol_exp));
        drain();

        // Zero amount in every mode, then ASR by 7 of 10000000
        for (int m = 0; m < 4; m++) send(N'($urandom), '0, 2'(m));
        send(8'b1000_0000, 3'd7, 2'b10);
        in_valid = 1'b0;
        repeat (L - 1) @(posedge clk);
        #1 check("asr_7", 32'(out_data), 32'hFF);
        drain();

        // Six beats with a four-cycle consumer stall mid-stream
        fork
            begin
                for (int i = 0; i < 6; i++) send(N'($urandom), W'($urandom), 2'($urandom));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                #2;
                held = out_data;
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                repeat (3) begin
                    @(posedge clk); #3;
                    check("stall_data_stable", 32'(out_data), 32'(held));
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Fill with three beats, then pulse reset between edges
        for (int i = 0; i < 3; i++) send(N'($urandom), W'($urandom), 2'($urandom));
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        sb.delete();
        in_cnt = 0;
        out_cnt = 0;
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("no_stale_beat", 32'(out_valid), 32'd0);
        send(8'h5A, 3'd1, 2'b01);
        in_valid = 1'b0;
        drain();

        // Random soak with random producer and consumer behaviour
        in_cnt = 0;
        out_cnt = 0;
        sent = 0;
        cyc = 0;
        pend = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            if (!pend) begin
                pend    = ($urandom_range(3) != 0);
                in_data = N'($urandom);
                in_amt  = W'($urandom);
                in_mode = 2'($urandom);
            end
            in_valid  = pend;
            out_ready = ($urandom_range(3) != 0);
            #1 acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                pend = 1'b0;
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("soak_beats_in", 32'(in_cnt), 32'd1000);
        check("soak_in_eq_out", 32'(out_cnt), 32'(in_cnt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
